// File: rtl/rx_arb_pkg.sv
// Shared types and sizing helpers for the RX port arbiter.
package rx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_GAP    = 2'd3
    } rx_arb_state_t;

    localparam int BYTE_CNT_W = 11;

    function automatic int port_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rx_rr_picker.sv
// Rotating-priority encoder: first requester after last_grant_i, wrapping modulo NUM_PORTS.
module rx_rr_picker
    import rx_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PW        = port_idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PW-1:0]        last_grant_i,
    output logic [PW-1:0]        winner_o,
    output logic                 found_o
);

    int idx;

    // Scan from lowest to highest priority so the closest requester overwrites the rest.
    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        idx      = 0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = (int'(last_grant_i) + i) % NUM_PORTS;
            if (req_i[idx]) begin
                winner_o = PW'(idx);
                found_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_port_arbiter.sv
// Frame-granular round-robin arbiter feeding the RX MAC parser from NUM_PORTS byte streams.
// Define RX_ARB_WATCHDOG_EN to truncate frames at MAX_FRAME_BYTES and drain the remainder.
module rx_port_arbiter
    import rx_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int IFG_CYCLES      = 2,
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [8*NUM_PORTS-1:0]       in_tdata,
    input  logic [NUM_PORTS-1:0]         in_tvalid,
    input  logic [NUM_PORTS-1:0]         in_tlast,
    output logic [NUM_PORTS-1:0]         in_tready,
    output logic [7:0]                   out_tdata,
    output logic                         out_tvalid,
    output logic                         out_tlast,
    input  logic                         out_tready,
    output logic [$clog2(NUM_PORTS)-1:0] out_port,
    output logic                         busy,
    output logic                         abort
);

    localparam int PW = port_idx_w(NUM_PORTS);
    localparam logic [PW-1:0] LAST_GRANT_RST = PW'(NUM_PORTS - 1);
    localparam logic [3:0]    GAP_LAST = 4'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam rx_arb_state_t END_STATE = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;

    rx_arb_state_t   state_q, state_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [PW-1:0]   last_grant_q, last_grant_d;
    logic [3:0]      gap_cnt_q, gap_cnt_d;

    logic [7:0]      port_data [NUM_PORTS];
    logic [7:0]      sel_data;
    logic            sel_valid, sel_last, stream_beat;
    logic [PW-1:0]   pick_idx;
    logic            pick_found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_data[gi] = in_tdata[8*gi +: 8];
        end
    endgenerate

    assign sel_data    = port_data[grant_q];
    assign sel_valid   = in_tvalid[grant_q];
    assign sel_last    = in_tlast[grant_q];
    assign stream_beat = (state_q == ST_STREAM) && sel_valid && out_tready;

    rx_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_picker (
        .req_i        (in_tvalid),
        .last_grant_i (last_grant_q),
        .winner_o     (pick_idx),
        .found_o      (pick_found)
    );

`ifdef RX_ARB_WATCHDOG_EN
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic                  abort_q, abort_d;
    logic                  wd_hit;

    // Beat that would reach the limit without its own tlast gets truncated.
    assign wd_hit = (byte_cnt_q == BYTE_CNT_W'(MAX_FRAME_BYTES - 1)) && !sel_last;
    assign abort  = abort_q;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        abort_d    = 1'b0;
        if ((state_q == ST_IDLE) && pick_found) begin
            byte_cnt_d = '0;
        end else if (stream_beat && (byte_cnt_q != '1)) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
        end
        if (stream_beat && wd_hit) begin
            abort_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            abort_q    <= abort_d;
        end
    end
`else
    logic wd_hit;
    logic unused_max_frame;
    assign wd_hit           = 1'b0;
    assign abort            = 1'b0;
    assign unused_max_frame = (MAX_FRAME_BYTES > 0);
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        gap_cnt_d    = gap_cnt_q;
        in_tready    = '0;
        out_tdata    = '0;
        out_tvalid   = 1'b0;
        out_tlast    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d      = pick_idx;
                    last_grant_d = pick_idx;
                    state_d      = ST_STREAM;
                end
            end
            ST_STREAM: begin
                out_tdata          = sel_data;
                out_tvalid         = sel_valid;
                out_tlast          = sel_last | wd_hit;
                in_tready[grant_q] = out_tready;
                if (stream_beat) begin
                    if (sel_last) begin
                        state_d   = END_STATE;
                        gap_cnt_d = '0;
                    end else if (wd_hit) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
`ifdef RX_ARB_WATCHDOG_EN
            ST_DRAIN: begin
                in_tready[grant_q] = 1'b1;
                if (sel_valid && sel_last) begin
                    state_d   = END_STATE;
                    gap_cnt_d = '0;
                end
            end
`endif
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_GRANT_RST;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign out_port = grant_q;
    assign busy     = (state_q == ST_STREAM) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_rx_port_arbiter.sv
// Directed bench for rx_port_arbiter: cycle table plus multi-cycle frame sequences.
module tb_rx_port_arbiter;

    localparam int N   = 4;
    localparam int IFG = 2;
`ifdef RX_ARB_WATCHDOG_EN
    localparam int MAXF = 32;
`else
    localparam int MAXF = 1518;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [8*N-1:0] in_tdata;
    logic [N-1:0]   in_tvalid, in_tlast, in_tready;
    logic [7:0]     out_tdata;
    logic           out_tvalid, out_tlast, out_tready;
    logic [1:0]     out_port;
    logic           busy, abort;

    rx_port_arbiter #(
        .NUM_PORTS       (N),
        .IFG_CYCLES      (IFG),
        .MAX_FRAME_BYTES (MAXF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tlast   (in_tlast),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tlast  (out_tlast),
        .out_tready (out_tready),
        .out_port   (out_port),
        .busy       (busy),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Source model per port, sink record of accepted output beats.
    logic [7:0] src_data [N][$];
    logic       src_last [N][$];
    logic [7:0] acc_data [$];
    logic       acc_last [$];
    logic [1:0] acc_port [$];
    int         acc_cyc  [$];
    logic [1:0] frame_ports [$];
    bit         in_frame, tog_mode, tog;
    int         cyc, leak_cnt, abort_cnt;

    task automatic clear_sink();
        acc_data.delete(); acc_last.delete(); acc_port.delete(); acc_cyc.delete();
        frame_ports.delete();
        in_frame = 0; cyc = 0; abort_cnt = 0;
    endtask

    task automatic clear_src();
        for (int p = 0; p < N; p++) begin
            src_data[p].delete();
            src_last[p].delete();
        end
    endtask

    task automatic load_frame(input int p, input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            src_data[p].push_back(base + 8'(i));
            src_last[p].push_back(i == len - 1);
        end
    endtask

    // Called at posedge+1: drive, observe at negedge, return at next posedge+1.
    task automatic cycle();
        in_tvalid = '0; in_tlast = '0; in_tdata = '0;
        for (int p = 0; p < N; p++) begin
            if (src_data[p].size() > 0) begin
                in_tvalid[p]        = 1'b1;
                in_tdata[8*p +: 8]  = src_data[p][0];
                in_tlast[p]         = src_last[p][0];
            end
        end
        out_tready = tog_mode ? tog : 1'b1;
        tog = ~tog;
        @(negedge clk);
        if ((in_tready & ~(4'b0001 << out_port)) != '0) leak_cnt++;
        if (abort) abort_cnt++;
        if (out_tvalid && out_tready) begin
            acc_data.push_back(out_tdata);
            acc_last.push_back(out_tlast);
            acc_port.push_back(out_port);
            acc_cyc.push_back(cyc);
            if (!in_frame) frame_ports.push_back(out_port);
            in_frame = !out_tlast;
        end
        for (int p = 0; p < N; p++) begin
            if (in_tvalid[p] && in_tready[p]) begin
                void'(src_data[p].pop_front());
                void'(src_last[p].pop_front());
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until(input string name, input int nbeats, input int budget);
        int k;
        k = 0;
        while (acc_data.size() < nbeats && k < budget) begin
            cycle();
            k++;
        end
        check({name, "_beats"}, acc_data.size(), nbeats);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_tvalid = '0; in_tlast = '0; in_tdata = '0; out_tready = 1'b1;
        tog_mode = 0; tog = 1;
        clear_src();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_sink();
    endtask

    typedef struct packed {
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic [31:0]  d;
        logic         rdy;
        logic         ev;
        logic         el;
        logic [7:0]   ed;
        logic [N-1:0] er;
        logic [1:0]   ep;
        logic         eb;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int errs;
        int nl;
        leak_cnt = 0;

        //          v        l        d             rdy  ev    el    ed     er       ep     eb
        tbl[0]  = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{4'b0010, 4'b0000, 32'h0000_A100, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0};
        tbl[2]  = '{4'b0011, 4'b0000, 32'h0000_A1B0, 1'b1, 1'b1, 1'b0, 8'hA1, 4'b0010, 2'd1, 1'b1};
        tbl[3]  = '{4'b0011, 4'b0010, 32'h0000_A2B0, 1'b1, 1'b1, 1'b1, 8'hA2, 4'b0010, 2'd1, 1'b1};
        tbl[4]  = '{4'b0001, 4'b0000, 32'h0000_00B0, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0};
        tbl[5]  = '{4'b0001, 4'b0000, 32'h0000_00B0, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0};
        tbl[6]  = '{4'b0011, 4'b0000, 32'h0000_A3B0, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0};
        tbl[7]  = '{4'b0011, 4'b0000, 32'h0000_A3B0, 1'b0, 1'b1, 1'b0, 8'hB0, 4'b0000, 2'd0, 1'b1};
        tbl[8]  = '{4'b0011, 4'b0001, 32'h0000_A3B1, 1'b1, 1'b1, 1'b1, 8'hB1, 4'b0001, 2'd0, 1'b1};
        tbl[9]  = '{4'b0010, 4'b0000, 32'h0000_A300, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0};
        tbl[10] = '{4'b0010, 4'b0000, 32'h0000_A300, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0};
        tbl[11] = '{4'b0010, 4'b0000, 32'h0000_A300, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0};
        tbl[12] = '{4'b0010, 4'b0010, 32'h0000_A300, 1'b1, 1'b1, 1'b1, 8'hA3, 4'b0010, 2'd1, 1'b1};
        tbl[13] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            in_tvalid = tbl[i].v; in_tlast = tbl[i].l; in_tdata = tbl[i].d; out_tready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {out_tvalid, out_tlast, out_tdata, in_tready, out_port, busy, abort},
                  {tbl[i].ev, tbl[i].el, tbl[i].ed, tbl[i].er, tbl[i].ep, tbl[i].eb, 1'b0});
            @(posedge clk);
            #1;
        end

        // Port 2 alone, 64 bytes, then a port-1 request right behind it.
        do_reset();
        load_frame(2, 64, 8'h01);
        run_until("t1", 64, 200);
        check("t1_first_cyc", acc_cyc[0], 1);
        check("t1_port", acc_port[0], 2);
        errs = 0; nl = 0;
        for (int i = 0; i < 64; i++) begin
            if (acc_data[i] !== 8'(i + 1)) errs++;
            if (acc_last[i]) nl++;
        end
        check("t1_data_errs", errs, 0);
        check("t1_tlast_64", {acc_last[63], 8'(nl)}, {1'b1, 8'd1});
        load_frame(1, 1, 8'hEE);
        run_until("t1_next", 65, 20);
        // GAP x IFG, one IDLE cycle to grant, then the beat.
        check("t1_ifg_delta", acc_cyc[64] - acc_cyc[63], IFG + 2);
        check("t1_next_port", acc_port[64], 1);

        // Ports 0, 1, 3 requesting continuously.
        do_reset();
        for (int f = 0; f < 2; f++) begin
            load_frame(0, 3, 8'h00 + 8'(f * 3));
            load_frame(1, 3, 8'h10 + 8'(f * 3));
            load_frame(3, 3, 8'h30 + 8'(f * 3));
        end
        run_until("t2", 18, 200);
        check("t2_order", {frame_ports[0], frame_ports[1], frame_ports[2],
                           frame_ports[3], frame_ports[4], frame_ports[5]},
                          {2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3});
        errs = 0;
        for (int i = 0; i < 18; i++) if (acc_data[i][5:4] !== acc_port[i]) errs++;
        check("t2_interleave_errs", errs, 0);

        // Toggling out_tready during a 10-byte frame.
        do_reset();
        tog_mode = 1;
        load_frame(3, 10, 8'h30);
        run_until("t3", 10, 100);
        errs = 0;
        for (int i = 0; i < 10; i++) if (acc_data[i] !== 8'h30 + 8'(i) || acc_port[i] !== 2'd3) errs++;
        check("t3_data_errs", errs, 0);
        check("t3_src_left", src_data[3].size(), 0);
        repeat (4) cycle();
        check("t3_no_extra", acc_data.size(), 10);
        tog_mode = 0;

        // Port 1 requests while port 0 is mid-frame.
        do_reset();
        load_frame(0, 30, 8'h40);
        repeat (3) cycle();
        load_frame(1, 20, 8'h80);
        run_until("t4", 50, 300);
        check("t4_order", {frame_ports[0], frame_ports[1]}, {2'd0, 2'd1});
        check("t4_p0_end", {acc_port[29], acc_last[29], acc_data[29]}, {2'd0, 1'b1, 8'h5D});
        check("t4_gap_ok", (acc_cyc[30] - acc_cyc[29]) >= IFG + 1, 1);
`ifndef RX_ARB_WATCHDOG_EN
        check("t4_abort_quiet", abort_cnt, 0);
`endif

        // Asynchronous reset at byte 5.
        do_reset();
        load_frame(1, 20, 8'hC0);
        run_until("t5", 5, 50);
        check("t5_streaming", {busy, out_port}, {1'b1, 2'd1});
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_rst", {out_tvalid, out_tlast, out_tdata, in_tready, out_port, busy, abort}, '0);
        clear_src();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_sink();
        load_frame(0, 2, 8'h01);
        load_frame(2, 2, 8'h21);
        run_until("t5_after", 4, 50);
        check("t5_tie", {frame_ports[0], frame_ports[1]}, {2'd0, 2'd2});

`ifdef RX_ARB_WATCHDOG_EN
        // 40-byte frame against a 32-byte limit.
        do_reset();
        load_frame(0, 40, 8'h01);
        load_frame(1, 1, 8'hAA);
        run_until("t6", 33, 200);
        check("t6_trunc", {acc_port[31], acc_last[31], acc_data[31]}, {2'd0, 1'b1, 8'h20});
        check("t6_next", {acc_port[32], acc_data[32]}, {2'd1, 8'hAA});
        check("t6_abort_once", abort_cnt, 1);
        check("t6_drained", src_data[0].size(), 0);
`endif

        check("tready_leaks", leak_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_port_arbiter.md
# rx_port_arbiter

Frame-granular round-robin arbiter that shares the single RX MAC parser between `NUM_PORTS` ingress byte streams. It sits between the per-port PHY/lane byte interfaces and the parser input. It grants one port at a time, passes that port's bytes through unchanged until its `tlast`, and inserts a configurable inter-frame gap. Frames are never interleaved at the parser.

## Interface
- `NUM_PORTS`, 4: number of ingress ports; legal range 2..8.
- `IFG_CYCLES`, 2: idle cycles forced after each frame end before the next grant; legal range 0..15.
- `MAX_FRAME_BYTES`, 1518: watchdog limit; used only when `RX_ARB_WATCHDOG_EN` is defined.
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset; asynchronous and active-high.
- `in_tdata`, in, 8*NUM_PORTS: port p byte at bits [8p+7:8p].
- `in_tvalid`, in, NUM_PORTS: per-port byte valid.
- `in_tlast`, in, NUM_PORTS: per-port last byte of frame.
- `in_tready`, out, NUM_PORTS: per-port accept.
- `out_tdata`, out, 8: byte to MAC parser.
- `out_tvalid`, out, 1: byte valid to parser.
- `out_tlast`, out, 1: frame end to parser.
- `out_tready`, in, 1: parser accept.
- `out_port`, out, $clog2(NUM_PORTS): index of the currently granted port.
- `busy`, out, 1: high in STREAM and DRAIN.
- `abort`, out, 1: one-cycle pulse on watchdog truncation.

## Operation
- A beat transfers when tvalid && tready, on both sides.
- States: IDLE, STREAM, DRAIN, GAP.
- IDLE
  - No port is ready and `out_tvalid`=0.
  - If any `in_tvalid` is high, pick the first requesting port in the order last_grant+1, last_grant+2, ... (mod NUM_PORTS).
  - Register the pick into `grant` and `last_grant`, then go to STREAM.
- STREAM
  - Combinational passthrough: `out_tdata`/`out_tvalid`/`out_tlast` come from port `grant`.
  - `in_tready[grant]` = `out_tready`; all other `in_tready` bits are 0.
  - When a beat with `out_tlast` is accepted: go to GAP if `IFG_CYCLES`>0, else go directly to IDLE.
- GAP: count `IFG_CYCLES` cycles with all outputs idle, then go to IDLE.
- DRAIN (watchdog only)
  - `in_tready[grant]`=1 and `out_tvalid`=0; bytes are discarded.
  - When the `in_tlast` beat is accepted, go to GAP (or IDLE if `IFG_CYCLES`=0).
- Requests are sampled only in IDLE. A port dropping `in_tvalid` mid-frame stalls STREAM; the grant is held.
- Simultaneous requests are resolved purely by round-robin order. No port is granted twice in a row while another port requests.
- Byte counter is 11 bits. It clears on grant, increments on each accepted STREAM beat, and saturates.

## Timing
- Reset values:
  - state=IDLE, `grant`=0, `last_grant`=NUM_PORTS-1 (so port 0 wins the first tie).
  - `in_tready`=0, `out_tvalid`=0, `out_tlast`=0, `out_tdata`=0.
  - `out_port`=0, `busy`=0, `abort`=0, counters=0.
- Arbitration latency: first byte can be accepted 1 cycle after the request is seen in IDLE.
- Data latency: 0 cycles in STREAM (no registers in the data path).
- Frame-to-frame: `IFG_CYCLES`+1 cycles minimum from the `tlast` acceptance to the first beat of the next frame.
- Reset mid-frame returns to IDLE immediately with outputs at reset values. The partially transferred frame is abandoned.
- `out_port` changes only on grant and is stable for the whole frame.

## Configuration
- `RX_ARB_WATCHDOG_EN` defined:
  - In STREAM, the beat that makes the byte count equal `MAX_FRAME_BYTES` without `in_tlast` is forwarded with `out_tlast` forced to 1.
  - `abort` pulses in the cycle after that beat is accepted, then the block goes to DRAIN.
- `RX_ARB_WATCHDOG_EN` undefined:
  - No byte counter and no DRAIN state; `abort` is tied to 0.
  - A frame holds the grant until its own `tlast`.

## Structure
- Package `rx_arb_pkg`:
  - `rx_arb_state_t` enum (IDLE, STREAM, DRAIN, GAP).
  - Byte-count width localparam (11).
  - Port-index width function.
- Sub-module `rx_rr_picker`:
  - Combinational rotate-priority encoder.
  - Inputs: request vector and `last_grant`. Outputs: winner index and found flag.
  - Instantiated once.

## Test plan
- Port 2 alone sends a 64-byte frame; `out_tready`=1 → grant on the next cycle, `out_port`=2, 64 bytes forwarded in order with `tlast` on byte 64, then 2 GAP cycles.
- Ports 0, 1, 3 request continuously after reset → grant order 0, 1, 3, 0, 1, 3; no back-to-back repeat.
- `out_tready` toggles 1/0 every cycle during a 10-byte frame → exactly 10 beats accepted, no duplicated or dropped bytes; non-granted `in_tready`=0 throughout.
- Port 1 asserts `tlast` on byte 20 while port 0 is mid-frame → port 1 is not granted until port 0's `tlast` plus IFG.
- `RX_ARB_WATCHDOG_EN`, `MAX_FRAME_BYTES`=32, port 0 sends 40 bytes → byte 32 is forwarded with `out_tlast`=1, `abort` pulses once, bytes 33–40 are drained, and the next grant follows IFG.
- `rst` asserted at byte 5 of a frame → all outputs return to reset values asynchronously; after release, port 0 wins the first tie.
